led_mode_sequencer: RTL and testbench
=====================================

LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SIMULATION, default 0; when non-zero, timers are shortened.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, blanking interval length in clocks (legal range 1..255).
REQ-004 SHALL define local DWELL_CYCLES = SIMULATION ? 1000 : 2*SYS_CLK_FREQ.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with the ports listed in REQ-006 to REQ-015.
REQ-006 clk_in  input  1  system clock; all logic on the rising edge.
REQ-007 reset_in  input  1  synchronous, active-high reset.
REQ-008 auto_en_in  input  1  1 = automatic sequencing, 0 = manual.
REQ-009 next_in  input  1  single-cycle request to advance immediately (auto mode only).
REQ-010 mode_sel_in  input  4  manual mode request.
REQ-011 colour_sel_in  input  3  manual colour, {blue,green,red}.
REQ-012 frame_done_in  input  1  single-cycle pulse from the display path at the end of the last row (address 15).
REQ-013 mode_out  output  4  mode to the pattern generator (0 OFF, 1 SOLID, 2 SCAN_H, 3 SCAN_V, 4 PULSE, 7 DEBUG_V).
REQ-014 colour_out  output  3  colour to the pattern generator.
REQ-015 blank_out, step_out  output  1 each  blank_out = 1 while blanking; step_out = single-cycle pulse when a new mode is applied.

Function
REQ-016 SHALL implement the states IDLE, DWELL, WAIT_FRAME and BLANK; all outputs SHALL be registered.
REQ-017 SHALL hold a 4-bit register cur_mode (the last applied mode) and a 4-bit register target.
REQ-018 SHALL use next(m) = 1->2, 2->3, 3->4, 4->1, and any other value -> 1.
REQ-019 IDLE, auto_en_in = 0: SHALL copy colour_sel_in to colour_out every cycle.
REQ-020 IDLE, auto_en_in = 0, mode_sel_in != cur_mode: SHALL load target = mode_sel_in and enter BLANK.
REQ-021 IDLE, auto_en_in = 1, cur_mode in 1..4: SHALL clear the dwell counter and enter DWELL.
REQ-022 IDLE, auto_en_in = 1, cur_mode not in 1..4: SHALL load target = 1 and enter WAIT_FRAME.
REQ-023 DWELL: the dwell counter SHALL increment each cycle.
REQ-024 DWELL: when the counter reaches DWELL_CYCLES-1, or next_in = 1, SHALL load target = next(cur_mode) and enter WAIT_FRAME.
REQ-025 DWELL: when both conditions of REQ-024 occur in the same cycle, SHALL take exactly one step.
REQ-026 DWELL, cur_mode = 4 on that step: colour_out SHALL advance 1->2->...->7->1, never 0, at the same edge.
REQ-027 WAIT_FRAME: SHALL enter BLANK on the first cycle with frame_done_in = 1 while in WAIT_FRAME; a pulse on the entry edge is not counted.
REQ-028 next_in SHALL be ignored outside DWELL.
REQ-029 Entering BLANK: on that same edge mode_out SHALL become 0 and blank_out SHALL become 1.
REQ-030 BLANK SHALL last exactly BLANK_CYCLES cycles.
REQ-031 Leaving BLANK: on the next edge mode_out = target, cur_mode = target, blank_out = 0, step_out = 1 for one cycle.
REQ-032 Leaving BLANK: SHALL go to DWELL (counter cleared) if auto_en_in = 1, else to IDLE.
REQ-033 auto_en_in falling in DWELL or WAIT_FRAME: SHALL go to IDLE at the next edge, with mode_out and colour_out unchanged.
REQ-034 auto_en_in changing in BLANK: SHALL not abort the blanking; it takes effect only at exit, per REQ-032.
REQ-035 The dwell counter SHALL be 32 bits wide and SHALL never wrap in DWELL.
REQ-036 The blank counter SHALL be 8 bits wide.

Reset
REQ-037 When reset_in = 1 at a clock edge: state = IDLE, mode_out = 0, cur_mode = 0, target = 0, colour_out = 3'b001, blank_out = 0, step_out = 0, counters = 0.
REQ-038 Reset SHALL take priority over every other input, including mid-BLANK and mid-DWELL.
REQ-039 Reset SHALL drop any pending target, so no step_out follows reset.

Verification (SIMULATION = 1, BLANK_CYCLES = 16)
REQ-040 Manual change: auto_en = 0, mode_sel 0->2 -> mode_out = 0 for 16 cycles with blank_out = 1, then mode_out = 2 and a single step_out pulse; no frame_done_in is needed.
REQ-041 Auto sequence: auto_en = 1 from mode 0, with frame_done pulsed every 50 cycles -> modes 1,2,3,4,1 applied; each dwell = 1000 cycles from step_out to WAIT_FRAME entry; colour_out 1->2 on the 4->1 step.
REQ-042 Frame gating: in WAIT_FRAME, frame_done held low for 500 cycles -> mode_out stays at the old mode, blank_out = 0; a pulse then produces a 16-cycle blank.
REQ-043 next_in pulsed at dwell count 10, and next_in coinciding with dwell expiry -> an early step, and exactly one step respectively.
REQ-044 Colour wrap: cur_mode = 4, colour = 7, step -> colour_out = 1, never 0.
REQ-045 Reset mid-BLANK (cycle 5 of 16) -> the next cycle shows mode_out = 0, colour_out = 1, state IDLE, and no step_out afterward.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer.
// Picks the display mode and colour for the pattern generator. In manual
// mode it follows mode_sel_in/colour_sel_in. In automatic mode it cycles
// through the modes SOLID, SCAN_H, SCAN_V and PULSE. Each mode dwells for a
// fixed time. Every mode change waits for a frame boundary, and the display
// is blanked briefly before the new mode is applied.
module led_mode_sequencer #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int SIMULATION   = 0,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       auto_en_in,
  input  logic       next_in,
  input  logic [3:0] mode_sel_in,
  input  logic [2:0] colour_sel_in,
  input  logic       frame_done_in,
  output logic [3:0] mode_out,
  output logic [2:0] colour_out,
  output logic       blank_out,
  output logic       step_out
);

  // Dwell length per mode: 2 s on hardware, 1000 clocks in simulation.
  localparam logic [31:0] DWELL_CYCLES =
    (SIMULATION != 0) ? 32'd1000 : 32'(2 * longint'(SYS_CLK_FREQ));
  localparam logic [31:0] DWELL_LAST = DWELL_CYCLES - 32'd1;
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYCLES - 1);

  localparam logic [3:0] MODE_OFF   = 4'd0;
  localparam logic [3:0] MODE_SOLID = 4'd1;
  localparam logic [3:0] MODE_PULSE = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_WAIT_FRAME,
    S_BLANK
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  curMode_q, curMode_d;
  logic [3:0]  target_q, target_d;
  logic [3:0]  mode_q, mode_d;
  logic [2:0]  colour_q, colour_d;
  logic        blank_q, blank_d;
  logic        step_q, step_d;
  logic [31:0] dwellCnt_q, dwellCnt_d;
  logic [7:0]  blankCnt_q, blankCnt_d;

  // The automatic sequence is 1-2-3-4-1. Any mode outside it, such as OFF
  // or DEBUG_V, re-enters the sequence at SOLID.
  function automatic logic [3:0] nextMode(input logic [3:0] m);
    logic [3:0] n;
    case (m)
      4'd1:    n = 4'd2;
      4'd2:    n = 4'd3;
      4'd3:    n = 4'd4;
      default: n = MODE_SOLID;
    endcase
    return n;
  endfunction

  // The colour walks through 1..7 and skips 0, because black would make
  // the display look switched off.
  function automatic logic [2:0] nextColour(input logic [2:0] c);
    logic [2:0] n;
    if (c == 3'd7 || c == 3'd0) begin
      n = 3'd1;
    end else begin
      n = c + 3'd1;
    end
    return n;
  endfunction

  function automatic logic inSequence(input logic [3:0] m);
    return (m >= MODE_SOLID) && (m <= MODE_PULSE);
  endfunction

  // Next-state logic. Every output register is updated here, so all
  // outputs change on a clock edge and never glitch combinationally.
  always_comb begin
    state_d    = state_q;
    curMode_d  = curMode_q;
    target_d   = target_q;
    mode_d     = mode_q;
    colour_d   = colour_q;
    blank_d    = blank_q;
    step_d     = 1'b0;
    dwellCnt_d = dwellCnt_q;
    blankCnt_d = blankCnt_q;

    case (state_q)
      S_IDLE: begin
        if (!auto_en_in) begin
          colour_d = colour_sel_in;
          if (mode_sel_in != curMode_q) begin
            target_d   = mode_sel_in;
            mode_d     = MODE_OFF;
            blank_d    = 1'b1;
            blankCnt_d = 8'd0;
            state_d    = S_BLANK;
          end
        end else if (inSequence(curMode_q)) begin
          dwellCnt_d = 32'd0;
          state_d    = S_DWELL;
        end else begin
          target_d = MODE_SOLID;
          state_d  = S_WAIT_FRAME;
        end
      end

      S_DWELL: begin
        if (!auto_en_in) begin
          state_d = S_IDLE;
        end else if ((dwellCnt_q == DWELL_LAST) || next_in) begin
          target_d = nextMode(curMode_q);
          if (curMode_q == MODE_PULSE) begin
            colour_d = nextColour(colour_q);
          end
          state_d = S_WAIT_FRAME;
        end else if (dwellCnt_q != 32'hFFFF_FFFF) begin
          dwellCnt_d = dwellCnt_q + 32'd1;
        end
      end

      S_WAIT_FRAME: begin
        if (!auto_en_in) begin
          state_d = S_IDLE;
        end else if (frame_done_in) begin
          mode_d     = MODE_OFF;
          blank_d    = 1'b1;
          blankCnt_d = 8'd0;
          state_d    = S_BLANK;
        end
      end

      S_BLANK: begin
        if (blankCnt_q == BLANK_LAST) begin
          mode_d     = target_q;
          curMode_d  = target_q;
          blank_d    = 1'b0;
          step_d     = 1'b1;
          blankCnt_d = 8'd0;
          if (auto_en_in) begin
            dwellCnt_d = 32'd0;
            state_d    = S_DWELL;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          blankCnt_d = blankCnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears any pending target, so no
  // step can appear after a reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      curMode_q  <= MODE_OFF;
      target_q   <= MODE_OFF;
      mode_q     <= MODE_OFF;
      colour_q   <= 3'b001;
      blank_q    <= 1'b0;
      step_q     <= 1'b0;
      dwellCnt_q <= 32'd0;
      blankCnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      curMode_q  <= curMode_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
      colour_q   <= colour_d;
      blank_q    <= blank_d;
      step_q     <= step_d;
      dwellCnt_q <= dwellCnt_d;
      blankCnt_q <= blankCnt_d;
    end
  end

  assign mode_out   = mode_q;
  assign colour_out = colour_q;
  assign blank_out  = blank_q;
  assign step_out   = step_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomized bench for led_mode_sequencer. A phase/countdown reference model
// predicts every output on every cycle.
module tb_led_mode_sequencer;

  localparam int BLANK = 16;
  localparam int DWELL = 1000;

  localparam int P_IDLE  = 0;
  localparam int P_DWELL = 1;
  localparam int P_WAIT  = 2;
  localparam int P_BLANK = 3;

  logic       clk;
  logic       reset_in;
  logic       auto_en_in;
  logic       next_in;
  logic [3:0] mode_sel_in;
  logic [2:0] colour_sel_in;
  logic       frame_done_in;
  logic [3:0] mode_out;
  logic [2:0] colour_out;
  logic       blank_out;
  logic       step_out;

  int checks = 0;
  int failures = 0;
  int dutSteps = 0;

  int mPhase, mCur, mTarget, mMode, mColour, mBlank, mStep;
  int mDwellAge, mBlankLeft, mStepCount;

  led_mode_sequencer #(
    .SYS_CLK_FREQ(100_000_000),
    .SIMULATION(1),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk_in(clk),
    .reset_in(reset_in),
    .auto_en_in(auto_en_in),
    .next_in(next_in),
    .mode_sel_in(mode_sel_in),
    .colour_sel_in(colour_sel_in),
    .frame_done_in(frame_done_in),
    .mode_out(mode_out),
    .colour_out(colour_out),
    .blank_out(blank_out),
    .step_out(step_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void startBlank(input int t);
    mTarget    = t;
    mMode      = 0;
    mBlank     = 1;
    mBlankLeft = BLANK;
    mPhase     = P_BLANK;
  endfunction

  // Reference model: advances one clock using the inputs applied for that clock.
  function automatic void modelStep(input logic rst, input logic auto, input logic nxt,
                                    input int msel, input int csel, input logic fd);
    if (rst) begin
      mPhase = P_IDLE; mCur = 0; mTarget = 0; mMode = 0; mColour = 1;
      mBlank = 0; mStep = 0; mDwellAge = 0; mBlankLeft = 0;
      return;
    end
    mStep = 0;
    case (mPhase)
      P_IDLE: begin
        if (!auto) begin
          mColour = csel;
          if (msel != mCur) startBlank(msel);
        end else if (mCur >= 1 && mCur <= 4) begin
          mPhase = P_DWELL; mDwellAge = 0;
        end else begin
          mTarget = 1; mPhase = P_WAIT;
        end
      end
      P_DWELL: begin
        if (!auto) mPhase = P_IDLE;
        else if (mDwellAge == DWELL - 1 || nxt) begin
          mTarget = (mCur >= 1 && mCur <= 3) ? mCur + 1 : 1;
          if (mCur == 4) mColour = (mColour % 7) + 1;
          mPhase = P_WAIT;
        end else begin
          mDwellAge++;
        end
      end
      P_WAIT: begin
        if (!auto) mPhase = P_IDLE;
        else if (fd) startBlank(mTarget);
      end
      default: begin
        mBlankLeft--;
        if (mBlankLeft == 0) begin
          mMode = mTarget; mCur = mTarget; mBlank = 0; mStep = 1; mStepCount++;
          if (auto) begin
            mPhase = P_DWELL; mDwellAge = 0;
          end else begin
            mPhase = P_IDLE;
          end
        end
      end
    endcase
  endfunction

  // Drives one clock of stimulus, then compares all outputs at the falling edge.
  task automatic applyStimulus(input logic rst, input logic auto, input logic nxt,
                               input logic [3:0] msel, input logic [2:0] csel,
                               input logic fd);
    reset_in      = rst;
    auto_en_in    = auto;
    next_in       = nxt;
    mode_sel_in   = msel;
    colour_sel_in = csel;
    frame_done_in = fd;
    modelStep(rst, auto, nxt, int'(msel), int'(csel), fd);
    @(posedge clk);
    @(negedge clk);
    if (step_out === 1'b1) dutSteps++;
    checkOutput("mode", 32'(mode_out), 32'(mMode));
    checkOutput("colour", 32'(colour_out), 32'(mColour));
    checkOutput("blank", 32'(blank_out), 32'(mBlank));
    checkOutput("step", 32'(step_out), 32'(mStep));
  endtask

  initial begin
    logic [3:0] msel;
    logic       nxt, fd, auto, rst, found;
    int         policy, holdTarget, waitAge, prevPhase, postSteps;

    mStepCount = 0;

    // Reset and its output values.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 3'd1, 1'b0);
    checkOutput("rst_mode", 32'(mode_out), 32'd0);
    checkOutput("rst_colour", 32'(colour_out), 32'd1);
    checkOutput("rst_blank", 32'(blank_out), 32'd0);
    checkOutput("rst_step", 32'(step_out), 32'd0);

    // Manual mode: the first change is 0->2, then random selections.
    // next_in and frame_done_in are noise here.
    msel = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if (i == 5) msel = 4'd2;
      else if (i % 40 == 5) msel = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, 1'b0, ($urandom_range(0, 9) == 0), msel,
                    3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end

    // Colour wrap: PULSE with colour 7, then an early step must give colour 1.
    repeat (30) applyStimulus(1'b0, 1'b0, 1'b0, 4'd4, 3'd7, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 4'd4, 3'd7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd4, 3'd7, 1'b0);
    checkOutput("wrap_colour", 32'(colour_out), 32'd1);

    // Automatic sequencing. Each dwell either expires, steps early at count
    // 10, steps together with expiry, or gets random next pulses. Each
    // frame wait releases after 0/1/49/500 cycles.
    policy = 0; holdTarget = 0; waitAge = 0;
    for (int i = 0; i < 14000; i++) begin
      nxt = 1'b0;
      if (mPhase == P_DWELL) begin
        case (policy)
          1:       nxt = (mDwellAge == 10);
          2:       nxt = (mDwellAge == DWELL - 1);
          3:       nxt = ($urandom_range(0, 199) == 0);
          default: nxt = 1'b0;
        endcase
      end else begin
        nxt = ($urandom_range(0, 99) == 0);
      end
      if (mPhase == P_WAIT) begin
        fd = (waitAge >= holdTarget);
        waitAge++;
      end else begin
        fd = ($urandom_range(0, 29) == 0);
      end
      prevPhase = mPhase;
      applyStimulus(1'b0, 1'b1, nxt, 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), fd);
      if (mStep == 1) policy = $urandom_range(0, 3);
      if (mPhase == P_WAIT && prevPhase != P_WAIT) begin
        waitAge = 0;
        case ($urandom_range(0, 3))
          0:       holdTarget = 0;
          1:       holdTarget = 1;
          2:       holdTarget = 49;
          default: holdTarget = 500;
        endcase
      end
    end

    // Mixed traffic: auto enable toggles, rare resets, manual changes.
    auto = 1'b1; msel = 4'd0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 149) == 0) auto = ~auto;
      if ($urandom_range(0, 59) == 0) msel = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 1999) == 0);
      applyStimulus(rst, auto, ($urandom_range(0, 99) == 0), msel,
                    3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
    end

    // Reset on cycle 5 of a blank: OFF, colour 1, and no step afterwards.
    msel = 4'(mCur + 1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mPhase == P_BLANK && mBlankLeft == BLANK - 4) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, msel, 3'd3, 1'b0);
    end
    checkOutput("blank_reached", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, msel, 3'd3, 1'b0);
    checkOutput("rstblank_mode", 32'(mode_out), 32'd0);
    checkOutput("rstblank_colour", 32'(colour_out), 32'd1);
    checkOutput("rstblank_blank", 32'(blank_out), 32'd0);
    postSteps = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 3'd1, 1'b0);
      if (step_out === 1'b1) postSteps++;
    end
    checkOutput("post_rst_steps", 32'(postSteps), 32'd0);

    checkOutput("step_total", 32'(dutSteps), 32'(mStepCount));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
